lcd1602_bus_writer: RTL
=======================

# lcd1602_bus_writer

HD44780/LCD1602 8-bit bus timing engine. It sits directly downstream of the LCD content/keyboard logic, which issues byte writes through a valid/ready handshake, and it drives the LCD pins. After reset it runs the power-on wait and the fixed initialisation sequence by itself. It then converts each accepted byte into a correctly timed enable pulse followed by the required execution wait, so upstream logic never counts microseconds.

## Interface
- `CLK_MHZ`, 27: clock frequency in MHz; all cycle counts are `X_US*CLK_MHZ`.
- `POR_US`, 40000: power-on wait before the first init write.
- `EN_US`, 1: LCD_EN high time.
- `EXEC_US`, 40: execution wait for normal commands and data.
- `LONG_US`, 1640: execution wait for clear (0x01) and home (0x02/0x03).

Ports:
- `clk_i`, in, 1: single clock for the whole block.
- `rst_i`, in, 1: reset; synchronous, active-high.
- `cmd_valid_i`, in, 1: byte write request.
- `cmd_ready_o`, out, 1: the block can accept a byte.
- `cmd_rs_i`, in, 1: 0 = command, 1 = data.
- `cmd_data_i`, in, 8: byte to write.
- `init_done_o`, out, 1: initialisation complete; stays high until reset.
- `LCD_RW`, out, 1: HD44780 R/W; constant 0 (write).
- `LCD_EN`, out, 1: enable strobe.
- `LCD_RS`, out, 1: register select.
- `LCD_DATA`, out, 8: data bus.

## Operation
- States: POR_WAIT → INIT_LOAD → SETUP → EN_HIGH → EXEC_WAIT → (INIT_LOAD | IDLE). IDLE → SETUP on accept.
- Reset values: all outputs 0. The state becomes POR_WAIT and the init index becomes 0.
- POR_WAIT: counts `POR_US*CLK_MHZ` cycles, then moves to INIT_LOAD.
- Init ROM, 7 entries, all with RS=0. Each entry is listed as data/wait class:
  - 0x38/INIT1, where INIT1 = 3×LONG.
  - 0x38/INIT2, where INIT2 = 3×EXEC.
  - 0x38/EXEC
  - 0x38/EXEC
  - 0x0C/EXEC
  - 0x01/LONG
  - 0x06/EXEC
- After the last init entry's EXEC_WAIT, the block sets `init_done_o`=1 and enters IDLE.
- Handshake:
  - `cmd_ready_o` = 1 only in IDLE.
  - A transfer occurs on an edge where `cmd_valid_i & cmd_ready_o`.
  - RS and data are captured into output registers on that edge.
  - `cmd_valid_i` while not ready is ignored, and upstream may change its data.
- Wait-class selection for host bytes: LONG if RS=0 and data ∈ {0x01, 0x02, 0x03}; EXEC otherwise.
- SETUP: EN=0 for 2 cycles with RS/DATA stable.
- EN_HIGH: EN=1 for `EN_US*CLK_MHZ` cycles.
- EXEC_WAIT: EN=0 for the selected wait. RS/DATA are held through EXEC_WAIT and until the next load, which guarantees hold time.
- Delay counter width: `$clog2(max(POR_US, 3*LONG_US)*CLK_MHZ+1)`. The counter loads N-1 and terminal count is 0, so each phase lasts exactly N cycles.
- Reset mid-operation (any state, including EN=1): outputs are 0 on the next edge and the full POR wait plus init sequence replays.

## Timing
- Accept at edge k:
  - LCD_RS/LCD_DATA are valid from cycle k+1.
  - LCD_EN=1 during cycles k+3 … k+2+EN_CYC.
  - `cmd_ready_o` rises at cycle k+2+EN_CYC+WAIT_CYC+1, i.e. one IDLE-entry cycle after the wait.
  - Minimum byte period: 3+EN_CYC+WAIT_CYC cycles.
- Defaults at 27 MHz:
  - EN_CYC = 27.
  - EXEC write: 1110-cycle period.
  - Clear: 44310-cycle period.
- Init entries use the same SETUP/EN/WAIT pattern. The first EN rise occurs at cycle POR_CYC+3 after reset release.
- No combinational path from inputs to outputs; all outputs are registered.

## Structure
- Package `lcd1602_pkg` holds:
  - the state enum;
  - the wait-class enum {W_EXEC, W_LONG, W_INIT1, W_INIT2};
  - the init ROM entry struct {rs, data, wait};
  - the 7-entry init ROM constant;
  - command constants CLEAR=0x01, HOME=0x02, FUNC_8B2L=0x38, DISP_ON=0x0C, ENTRY_INC=0x06.
- Sub-module `lcd1602_delay_cnt`: loadable down-counter with a `zero_o` flag, parameterised width, synchronous reset. One instance is shared by all phases.

## Test plan
Bench parameters: CLK_MHZ=1, POR_US=50, EN_US=2, EXEC_US=4, LONG_US=10.

1. Reset, then release → LCD_EN=0 and `cmd_ready_o`=0 for 50 cycles; first EN rise at cycle 53 with DATA=0x38, RS=0, RW=0.
2. Run init → EN pulses carry 0x38, 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06. Gaps after pulses 1 and 2 are 30 and 12 cycles. `init_done_o` and `cmd_ready_o` rise together after the 0x06 wait.
3. Data write: RS=1, 0x41, accepted at edge k → DATA=0x41 and RS=1 from k+1; EN=1 exactly in cycles k+3 and k+4; `cmd_ready_o` returns at k+9.
4. Command 0x01, RS=0 → LONG wait; `cmd_ready_o` returns at k+15. Command 0x80 → ready returns at k+9.
5. `cmd_valid_i` held high while the data stream changes across 0x48, 0x49, 0x21 → exactly three EN pulses, one per accepted byte, in order. Values presented while ready=0 are never written.
6. `rst_i` pulsed during EN=1 → next cycle EN/RS/DATA/ready/init_done are all 0. The POR wait of 50 cycles and the full init sequence repeat.

Source files
------------

// File: rtl/lcd1602_pkg.sv
// Shared types and constants for the LCD1602 bus writer: FSM states, wait classes
// and the fixed power-on initialisation ROM.
package lcd1602_pkg;

  typedef enum logic [2:0] {
    StPorWait,
    StInitLoad,
    StSetup,
    StEnHigh,
    StExecWait,
    StIdle
  } state_e;

  typedef enum logic [1:0] {
    W_EXEC,
    W_LONG,
    W_INIT1,
    W_INIT2
  } wait_e;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
    wait_e      wait_cls;
  } init_entry_t;

  localparam logic [7:0] CLEAR     = 8'h01;
  localparam logic [7:0] HOME      = 8'h02;
  localparam logic [7:0] FUNC_8B2L = 8'h38;
  localparam logic [7:0] DISP_ON   = 8'h0C;
  localparam logic [7:0] ENTRY_INC = 8'h06;

  localparam int unsigned InitLen = 7;

  localparam init_entry_t INIT_ROM [InitLen] = '{
    '{1'b0, FUNC_8B2L, W_INIT1},
    '{1'b0, FUNC_8B2L, W_INIT2},
    '{1'b0, FUNC_8B2L, W_EXEC},
    '{1'b0, FUNC_8B2L, W_EXEC},
    '{1'b0, DISP_ON,   W_EXEC},
    '{1'b0, CLEAR,     W_LONG},
    '{1'b0, ENTRY_INC, W_EXEC}
  };

  // Clear and both home encodings (0x02/0x03) need the long execution time.
  function automatic wait_e host_wait(logic rs, logic [7:0] data);
    return (!rs && (data == CLEAR || data == HOME || data == 8'h03)) ? W_LONG : W_EXEC;
  endfunction

endpackage

// File: rtl/lcd1602_delay_cnt.sv
// Loadable down-counter shared by every timed phase; holds at zero and flags it.
module lcd1602_delay_cnt #(
  parameter int unsigned      Width    = 16,
  parameter logic [Width-1:0] ResetVal = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             zero_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= ResetVal;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lcd1602_bus_writer.sv
// HD44780 8-bit bus timing engine: power-on wait, fixed init sequence, then one
// timed enable pulse plus execution wait per byte accepted over valid/ready.
module lcd1602_bus_writer
  import lcd1602_pkg::*;
#(
  parameter int unsigned CLK_MHZ = 27,
  parameter int unsigned POR_US  = 40000,
  parameter int unsigned EN_US   = 1,
  parameter int unsigned EXEC_US = 40,
  parameter int unsigned LONG_US = 1640
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic       cmd_rs_i,
  input  logic [7:0] cmd_data_i,
  output logic       init_done_o,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic       LCD_RS,
  output logic [7:0] LCD_DATA
);

  localparam int unsigned PorCyc   = POR_US * CLK_MHZ;
  localparam int unsigned EnCyc    = EN_US * CLK_MHZ;
  localparam int unsigned ExecCyc  = EXEC_US * CLK_MHZ;
  localparam int unsigned LongCyc  = LONG_US * CLK_MHZ;
  localparam int unsigned Init1Cyc = 3 * LongCyc;
  localparam int unsigned Init2Cyc = 3 * ExecCyc;
  localparam int unsigned SetupCyc = 2;
  localparam int unsigned MaxCyc   = (PorCyc > Init1Cyc) ? PorCyc : Init1Cyc;
  localparam int unsigned CntW     = $clog2(MaxCyc + 1);

  // The counter is loaded with N-1 and expires at 0, so each phase is exactly N cycles.
  localparam logic [CntW-1:0] PorLoad   = CntW'(PorCyc - 1);
  localparam logic [CntW-1:0] SetupLoad = CntW'(SetupCyc - 1);
  localparam logic [CntW-1:0] EnLoad    = CntW'(EnCyc - 1);
  localparam logic [CntW-1:0] ExecLoad  = CntW'(ExecCyc - 1);
  localparam logic [CntW-1:0] LongLoad  = CntW'(LongCyc - 1);
  localparam logic [CntW-1:0] Init1Load = CntW'(Init1Cyc - 1);
  localparam logic [CntW-1:0] Init2Load = CntW'(Init2Cyc - 1);
  localparam logic [2:0]      InitLast  = 3'(InitLen - 1);

  state_e     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  wait_e      wait_q, wait_d;
  logic       rs_q, rs_d;
  logic [7:0] data_q, data_d;
  logic       done_q, done_d;
  logic       en_q, ready_q;

  logic            cnt_load;
  logic [CntW-1:0] cnt_val;
  logic [CntW-1:0] wait_load;
  logic            cnt_zero;

  lcd1602_delay_cnt #(
    .Width    (CntW),
    .ResetVal (PorLoad)
  ) u_delay_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    wait_load = ExecLoad;
    unique case (wait_q)
      W_EXEC:  wait_load = ExecLoad;
      W_LONG:  wait_load = LongLoad;
      W_INIT1: wait_load = Init1Load;
      W_INIT2: wait_load = Init2Load;
      default: wait_load = ExecLoad;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    wait_d   = wait_q;
    rs_d     = rs_q;
    data_d   = data_q;
    done_d   = done_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    unique case (state_q)
      StPorWait: begin
        if (cnt_zero) state_d = StInitLoad;
      end
      StInitLoad: begin
        rs_d     = INIT_ROM[idx_q].rs;
        data_d   = INIT_ROM[idx_q].data;
        wait_d   = INIT_ROM[idx_q].wait_cls;
        cnt_load = 1'b1;
        cnt_val  = SetupLoad;
        state_d  = StSetup;
      end
      StIdle: begin
        if (cmd_valid_i) begin
          rs_d     = cmd_rs_i;
          data_d   = cmd_data_i;
          wait_d   = host_wait(cmd_rs_i, cmd_data_i);
          cnt_load = 1'b1;
          cnt_val  = SetupLoad;
          state_d  = StSetup;
        end
      end
      StSetup: begin
        if (cnt_zero) begin
          cnt_load = 1'b1;
          cnt_val  = EnLoad;
          state_d  = StEnHigh;
        end
      end
      StEnHigh: begin
        if (cnt_zero) begin
          cnt_load = 1'b1;
          cnt_val  = wait_load;
          state_d  = StExecWait;
        end
      end
      StExecWait: begin
        if (cnt_zero) begin
          if (done_q || idx_q == InitLast) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = StInitLoad;
          end
        end
      end
      default: state_d = StPorWait;
    endcase
  end

  // EN and ready are registered from the next state so they line up with it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StPorWait;
      idx_q   <= 3'd0;
      wait_q  <= W_EXEC;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      done_q  <= 1'b0;
      en_q    <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      done_q  <= done_d;
      en_q    <= (state_d == StEnHigh);
      ready_q <= (state_d == StIdle);
    end
  end

  assign cmd_ready_o = ready_q;
  assign init_done_o = done_q;
  assign LCD_RW      = 1'b0;
  assign LCD_EN      = en_q;
  assign LCD_RS      = rs_q;
  assign LCD_DATA    = data_q;

endmodule
